// File: rtl/mipi_csi_rx_packet_decoder.sv
// CSI-2 receive packet decoder: strips header/CRC from 1/2/4-lane byte streams,
// forwards payload bytes earliest-first on [3] and pulses short-packet sync events.
module mipi_csi_rx_packet_decoder (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [2:0]      active_lanes_i,
    input  logic [3:0][7:0] byte_data_i,
    input  logic            byte_valid_i,
    output logic [3:0][7:0] payload_data_o,
    output logic [3:0]      payload_valid_o,
    output logic [5:0]      data_type_o,
    output logic [1:0]      virtual_channel_o,
    output logic [15:0]     word_count_o,
    output logic            frame_start_o,
    output logic            frame_end_o,
    output logic            line_start_o,
    output logic            line_end_o,
    output logic            err_trunc_o
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CRC,
        WAIT_LOW
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      lanes_q, lanes_d;
    logic [1:0]      hcnt_q, hcnt_d;
    logic [2:0][7:0] hdr_q, hdr_d;
    logic [16:0]     cnt_q, cnt_d;
    logic [5:0]      dt_q, dt_d;
    logic [1:0]      vc_q, vc_d;
    logic [15:0]     wc_q, wc_d;
    logic [3:0][7:0] pdata_q, pdata_d;
    logic [3:0]      pvalid_q, pvalid_d;
    logic [3:0]      pulse_q, pulse_d;
    logic            err_q, err_d;

    logic [2:0]      lanes;
    logic [1:0]      hbase;
    logic [2:0]      idx;
    logic [2:0][7:0] hdr_m;
    logic            hdr_done;
    logic            hdr_take;
    logic [16:0]     paycnt;
    logic [5:0]      dt_m;

    always_comb begin
        state_d  = state_q;
        lanes_d  = lanes_q;
        hcnt_d   = hcnt_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        dt_d     = dt_q;
        vc_d     = vc_q;
        wc_d     = wc_q;
        pdata_d  = '0;
        pvalid_d = '0;
        pulse_d  = '0;
        err_d    = 1'b0;
        hdr_take = 1'b0;
        idx      = '0;

        // Header bytes are merged with those already captured; the ECC byte is dropped.
        lanes = (state_q == IDLE) ? active_lanes_i : lanes_q;
        hbase = (state_q == IDLE) ? 2'd0 : hcnt_q;
        hdr_m = hdr_q;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = {1'b0, hbase} + 3'(k);
            if (3'(k) < lanes && idx < 3'd3) hdr_m[idx[1:0]] = byte_data_i[k];
        end
        hdr_done = (({1'b0, hbase} + lanes) == 3'd4);
        dt_m     = hdr_m[0][5:0];
        paycnt   = cnt_q - 17'd2;

        case (state_q)
            IDLE: begin
                if (byte_valid_i && (lanes == 3'd1 || lanes == 3'd2 || lanes == 3'd4))
                    hdr_take = 1'b1;
            end
            HEADER: begin
                if (!byte_valid_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    hdr_take = 1'b1;
                end
            end
            PAYLOAD, CRC: begin
                if (!byte_valid_i) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (state_q == PAYLOAD) begin
                        for (int unsigned k = 0; k < 4; k++) begin
                            if (3'(k) < lanes_q && 17'(k) < paycnt) begin
                                pdata_d[2'(3 - k)]  = byte_data_i[k];
                                pvalid_d[2'(3 - k)] = 1'b1;
                            end
                        end
                    end
                    // cnt_q counts payload plus CRC bytes still outstanding.
                    if (cnt_q <= 17'(lanes_q)) begin
                        cnt_d   = '0;
                        state_d = WAIT_LOW;
                    end else begin
                        cnt_d   = cnt_q - 17'(lanes_q);
                        state_d = (cnt_d <= 17'd2) ? CRC : PAYLOAD;
                    end
                end
            end
            WAIT_LOW: begin
                if (!byte_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (hdr_take) begin
            lanes_d = lanes;
            hdr_d   = hdr_m;
            hcnt_d  = hbase + lanes[1:0];
            if (!hdr_done) begin
                state_d = HEADER;
            end else begin
                hcnt_d = '0;
                vc_d   = hdr_m[0][7:6];
                wc_d   = {hdr_m[2], hdr_m[1]};
                if (dt_m < 6'h10) begin
                    if (dt_m < 6'h04) pulse_d[dt_m[1:0]] = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    dt_d    = dt_m;
                    cnt_d   = {1'b0, hdr_m[2], hdr_m[1]} + 17'd2;
                    state_d = ({hdr_m[2], hdr_m[1]} == 16'd0) ? CRC : PAYLOAD;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            lanes_q  <= '0;
            hcnt_q   <= '0;
            hdr_q    <= '0;
            cnt_q    <= '0;
            dt_q     <= '0;
            vc_q     <= '0;
            wc_q     <= '0;
            pdata_q  <= '0;
            pvalid_q <= '0;
            pulse_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lanes_q  <= lanes_d;
            hcnt_q   <= hcnt_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            dt_q     <= dt_d;
            vc_q     <= vc_d;
            wc_q     <= wc_d;
            pdata_q  <= pdata_d;
            pvalid_q <= pvalid_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
        end
    end

    assign payload_data_o    = pdata_q;
    assign payload_valid_o   = pvalid_q;
    assign data_type_o       = dt_q;
    assign virtual_channel_o = vc_q;
    assign word_count_o      = wc_q;
    assign frame_start_o     = pulse_q[0];
    assign frame_end_o       = pulse_q[1];
    assign line_start_o      = pulse_q[2];
    assign line_end_o        = pulse_q[3];
    assign err_trunc_o       = err_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder.sv
// Randomized bench: packets are built as byte streams and expected outputs are
// derived from each byte's position within the packet.
module tb_mipi_csi_rx_packet_decoder;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [2:0]      active_lanes_i;
    logic [3:0][7:0] byte_data_i;
    logic            byte_valid_i;
    logic [3:0][7:0] payload_data_o;
    logic [3:0]      payload_valid_o;
    logic [5:0]      data_type_o;
    logic [1:0]      virtual_channel_o;
    logic [15:0]     word_count_o;
    logic            frame_start_o, frame_end_o, line_start_o, line_end_o, err_trunc_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0]  m_dt = '0;
    logic [1:0]  m_vc = '0;
    logic [15:0] m_wc = '0;

    mipi_csi_rx_packet_decoder dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .active_lanes_i    (active_lanes_i),
        .byte_data_i       (byte_data_i),
        .byte_valid_i      (byte_valid_i),
        .payload_data_o    (payload_data_o),
        .payload_valid_o   (payload_valid_o),
        .data_type_o       (data_type_o),
        .virtual_channel_o (virtual_channel_o),
        .word_count_o      (word_count_o),
        .frame_start_o     (frame_start_o),
        .frame_end_o       (frame_end_o),
        .line_start_o      (line_start_o),
        .line_end_o        (line_end_o),
        .err_trunc_o       (err_trunc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Apply one input cycle and check the registered response one edge later.
    // Pulse vector order: {frame_start, frame_end, line_start, line_end, err_trunc}.
    task automatic cyc(input logic rst, input logic v, input logic [2:0] ln,
                       input logic [3:0][7:0] d, input logic [3:0] epv,
                       input logic [3:0][7:0] epd, input logic [4:0] epul);
        reset_i        = rst;
        byte_valid_i   = v;
        active_lanes_i = ln;
        byte_data_i    = d;
        @(posedge clk_i);
        #1;
        check_eq("pvalid", 32'(payload_valid_o), 32'(epv));
        check_eq("pdata", 32'(payload_data_o), 32'(epd));
        check_eq("dt", 32'(data_type_o), 32'(m_dt));
        check_eq("vc", 32'(virtual_channel_o), 32'(m_vc));
        check_eq("wc", 32'(word_count_o), 32'(m_wc));
        check_eq("pulses", 32'({frame_start_o, frame_end_o, line_start_o, line_end_o, err_trunc_o}),
                 32'(epul));
    endtask

    task automatic idle_cycle(input logic v, input logic [2:0] ln);
        cyc(1'b0, v, ln, 32'($urandom), 4'b0, '0, 5'b0);
    endtask

    task automatic send_pkt(input int n, input logic [7:0] di, input logic [15:0] wc,
                            input int cut, input int rst_at, input int tail);
        logic [7:0]      q[$];
        logic [3:0][7:0] d, epd;
        logic [3:0]      epv;
        logic [4:0]      epul;
        logic [2:0]      ln;
        bit              is_long;
        int              total, ncyc, idx;
        is_long = (di[5:0] >= 6'h10);
        q = {di, wc[7:0], wc[15:8], 8'($urandom)};
        if (is_long) begin
            for (int i = 0; i < int'(wc) + 2; i++) q.push_back(8'($urandom));
        end
        total = q.size();
        ncyc  = (total + n - 1) / n;
        for (int c = 0; c < ncyc; c++) begin
            d = 32'($urandom);
            if (c == rst_at) begin
                m_dt = '0; m_vc = '0; m_wc = '0;
                cyc(1'b1, 1'b1, 3'(n), d, 4'b0, '0, 5'b0);
                return;
            end
            if (c == cut) begin
                cyc(1'b0, 1'b0, 3'(n), d, 4'b0, '0, 5'b00001);
                return;
            end
            epv = '0; epd = '0; epul = '0;
            for (int k = 0; k < n; k++) begin
                idx = c * n + k;
                if (idx < total) d[k] = q[idx];
                if (is_long && idx >= 4 && idx < 4 + int'(wc)) begin
                    epv[3 - k] = 1'b1;
                    epd[3 - k] = d[k];
                end
            end
            if (c * n <= 3 && 3 < c * n + n) begin
                m_vc = di[7:6];
                m_wc = wc;
                if (is_long) m_dt = di[5:0];
                else if (di[5:0] < 6'h04) epul = 5'b10000 >> di[5:0];
            end
            ln = (c == 0) ? 3'(n) : 3'($urandom_range(0, 7));
            cyc(1'b0, 1'b1, ln, d, epv, epd, epul);
        end
        for (int t = 0; t < tail; t++) idle_cycle(1'b1, 3'($urandom_range(0, 7)));
        idle_cycle(1'b0, 3'($urandom_range(0, 7)));
    endtask

    function automatic int pick_lanes();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 1 : (r == 1) ? 2 : 4;
    endfunction

    initial begin
        int         n, cut, rst_at, ncyc, r;
        logic [7:0] di;
        logic [15:0] wc;
        logic [2:0] bad_ln [5] = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};

        reset_i = 1'b1; byte_valid_i = 1'b0; active_lanes_i = 3'd4; byte_data_i = '0;
        cyc(1'b1, 1'b0, 3'd4, 32'($urandom), 4'b0, '0, 5'b0);
        cyc(1'b1, 1'b1, 3'd4, 32'($urandom), 4'b0, '0, 5'b0);

        send_pkt(4, 8'h2A, 16'd6, -1, -1, 0);
        send_pkt(2, 8'h1E, 16'd3, -1, -1, 1);
        send_pkt(1, 8'h00, 16'h1234, -1, -1, 0);
        send_pkt(4, 8'h55, 16'd0, -1, -1, 0);
        send_pkt(4, 8'h91, 16'd5, -1, -1, 0);
        send_pkt(4, 8'h20, 16'd8, 2, -1, 0);
        send_pkt(2, 8'h63, 16'd7, -1, -1, 2);
        send_pkt(4, 8'h30, 16'd12, -1, 2, 0);
        send_pkt(4, 8'hC1, 16'h0ABC, -1, -1, 0);
        for (int i = 0; i < 5; i++) idle_cycle(1'b1, bad_ln[i]);
        send_pkt(1, 8'h2F, 16'd5, -1, -1, 0);

        for (int p = 0; p < 250; p++) begin
            n = pick_lanes();
            r = $urandom_range(0, 99);
            if (r < 25)      di = {2'($urandom), 6'($urandom_range(0, 3))};
            else if (r < 35) di = {2'($urandom), 6'($urandom_range(4, 15))};
            else             di = {2'($urandom), 6'($urandom_range(16, 63))};
            wc = (di[5:0] >= 6'h10) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            ncyc = (di[5:0] >= 6'h10) ? (4 + int'(wc) + 2 + n - 1) / n : 4 / n;
            cut = -1; rst_at = -1;
            r = $urandom_range(0, 99);
            if (r < 15 && ncyc > 1) cut = $urandom_range(1, ncyc - 1);
            else if (r < 20)        rst_at = $urandom_range(0, ncyc - 1);
            if ($urandom_range(0, 9) == 0) idle_cycle(1'b1, bad_ln[$urandom_range(0, 4)]);
            send_pkt(n, di, wc, cut, rst_at, $urandom_range(0, 2));
        end

        send_pkt(4, 8'h7F, 16'hFFFF, -1, -1, 0);
        send_pkt(2, 8'h12, 16'd4, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
